// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the memory arbiter and the CPU top that instantiates it.
//   AW_DEF / DW_DEF : default address / data widths of the CPU bus.
//   MAX_WAIT_DEF    : default number of denied host cycles before host priority.
//   CNT_W           : width of the host starvation counter.
//   gnt_e           : grant encoding (GNT_NONE, GNT_CPU, GNT_HOST).
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int AW_DEF       = 6;
  localparam int DW_DEF       = 8;
  localparam int MAX_WAIT_DEF = 4;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_HOST = 2'd2
  } gnt_e;

endpackage

// File: rtl/arb_wait_counter.sv
// -----------------------------------------------------------------------------
// arb_wait_counter
// Counts consecutive cycles in which the host was denied the memory.
// The count saturates at MAX_WAIT. When it sits at MAX_WAIT, force_host tells
// the arbiter to give the next slot to the host.
// Ports:
//   clk, reset  : clock and asynchronous active-low reset.
//   clr         : clear the count (host granted, or host not requesting).
//   inc         : host requesting but denied this cycle.
//   force_host  : count has reached MAX_WAIT.
// MAX_WAIT must lie in 1..15 so that it fits the 4-bit counter.
// -----------------------------------------------------------------------------
module arb_wait_counter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic force_host
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, whatever the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_CNT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign force_host = (cnt == MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single-port program/data memory between the CPU bus and a host
// loader/debug port. The CPU wins by default. After MAX_WAIT consecutive denied
// host cycles, the host is given one slot, and the CPU is stalled by cpu_hold.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset.
//   cpu_rd/wr/adr/wdata : CPU bus request.  cpu_rdata = mem_rdata.
//   cpu_hold            : CPU denied this cycle; it must freeze its request.
//   host_req/wr/adr/wdata : host request (one access per grant).
//   host_gnt            : host access performed this cycle.
//   host_rdata/rvalid   : registered host read data, one-cycle valid pulse.
//   mem_*               : memory port (mem_rdata is combinational in mem_rd).
//   err                 : sticky flag, set by cpu_rd & cpu_wr together.
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_hold,
  input  logic          host_req,
  input  logic          host_wr,
  input  logic [AW-1:0] host_adr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic [AW-1:0] mem_adr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  logic cpu_illegal;
  logic cpu_req;
  logic force_host;
  gnt_e gnt;

  // A cycle with both CPU strobes is flagged and then ignored, so the host
  // may take the slot.
  assign cpu_illegal = cpu_rd & cpu_wr;
  assign cpu_req     = (cpu_rd | cpu_wr) & ~cpu_illegal;

  arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_counter (
    .clk        (clk),
    .reset      (reset),
    .clr        ((gnt == GNT_HOST) | ~host_req),
    .inc        (host_req & (gnt == GNT_CPU)),
    .force_host (force_host)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (cpu_req && !(host_req && force_host)) begin
      gnt = GNT_CPU;
    end else if (host_req) begin
      gnt = GNT_HOST;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    mem_adr   = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    cpu_hold  = 1'b0;
    host_gnt  = 1'b0;
    unique case (gnt)
      GNT_CPU: begin
        mem_adr   = cpu_adr;
        mem_wdata = cpu_wdata;
        mem_rd    = cpu_rd & ~cpu_wr;
        mem_wr    = cpu_wr & ~cpu_rd;
      end
      GNT_HOST: begin
        mem_adr   = host_adr;
        mem_wdata = host_wdata;
        mem_rd    = ~host_wr;
        mem_wr    = host_wr;
        host_gnt  = 1'b1;
        cpu_hold  = cpu_req;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = mem_rdata;

  // Host read data is captured on the edge that closes the grant. A read that
  // is cut off by reset never produces rvalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= 1'b0;
      if ((gnt == GNT_HOST) && !host_wr) begin
        host_rdata  <= mem_rdata;
        host_rvalid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (cpu_illegal) begin
      err <= 1'b1;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port program/data memory between the adding CPU (controller/datapath bus) and a host loader/debug port.
- Sits between the CPU bus pins (6-bit address, 8-bit data, rd/wr strobes) and the memory.
- The CPU has default priority. A starvation counter guarantees the host a slot within a bounded number of cycles.
- The CPU is stalled through cpu_hold, which top-level glue ANDs into the CPU clock enable.

Parameters:
- AW, 6, address width (matches the CPU adr_bus)
- DW, 8, data width (matches the CPU data_bus)
- MAX_WAIT, 4, consecutive denied host cycles before the host is forced priority (range 1..15)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_rd  in  1  CPU read request
- cpu_wr  in  1  CPU write request
- cpu_adr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data (split from the inout bus by top glue)
- cpu_rdata  out  DW  read data to CPU; equals mem_rdata
- cpu_hold  out  1  CPU denied this cycle; CPU must freeze and hold its request
- host_req  in  1  host access request
- host_wr  in  1  1 = write, 0 = read
- host_adr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host access performed this cycle
- host_rdata  out  DW  registered host read data
- host_rvalid  out  1  host_rdata valid (one-cycle pulse)
- mem_adr  out  AW  memory address
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, combinational during mem_rd
- err  out  1  sticky protocol-error flag

Behaviour:
- Definitions:
  - cpu_req = cpu_rd | cpu_wr.
  - Grant is a combinational decision from the requests and registered state.
  - Each grant is one access in one cycle; there are no bursts.
- Grant rule:
  - force = (wait_cnt == MAX_WAIT).
  - Grant goes to the CPU if cpu_req & !(host_req & force).
  - Otherwise it goes to the host if host_req.
  - Otherwise no grant.
- Outputs when the CPU is granted:
  - mem_adr = cpu_adr, mem_wdata = cpu_wdata.
  - mem_rd = cpu_rd & !cpu_wr, mem_wr = cpu_wr & !cpu_rd.
  - cpu_hold = 0.
- Outputs when the host is granted:
  - mem_adr = host_adr, mem_wdata = host_wdata.
  - mem_rd = !host_wr, mem_wr = host_wr.
  - host_gnt = 1.
  - cpu_hold = cpu_req.
- No grant:
  - mem_rd = mem_wr = 0; mem_adr and mem_wdata hold 0.
  - cpu_hold = 0, host_gnt = 0.
- wait_cnt (4-bit register):
  - Clears on a host grant, or when host_req = 0.
  - Increments (saturating at MAX_WAIT) when host_req = 1 and the grant goes to the CPU.
- Host read timing:
  - On the edge closing a host read grant: host_rdata <= mem_rdata and host_rvalid <= 1.
  - Otherwise host_rvalid <= 0, and host_rdata holds its value.
- CPU read data: cpu_rdata = mem_rdata unregistered; the CPU keeps its own timing.
- Error handling:
  - cpu_rd & cpu_wr in the same cycle sets err.
  - The cycle is then treated as no CPU request: neither strobe, and the host may take the slot.
  - err clears only on reset.
- Reset (async, reset = 0) forces, immediately:
  - wait_cnt = 0, host_rvalid = 0, host_rdata = 0, err = 0.
  - All combinational outputs follow from the reset registers and current inputs.
  - A pending host read dropped by reset produces no rvalid.
- Boundary cases:
  - Host alone: granted every cycle, back-to-back.
  - CPU continuous with host waiting: the host is granted on cycle MAX_WAIT+1; the CPU then wins the next cycle.
  - host_req dropped while waiting: the counter clears, with no late grant.
  - Host request changed while waiting: sampled address and data are taken in the grant cycle only.
  - Worst-case latency: host MAX_WAIT+1 cycles; CPU stalled at most one cycle per MAX_WAIT+1.

Decomposition:
- Shared package holds:
  - AW and DW defaults, shared with the CPU top.
  - Grant encoding constants GNT_NONE = 2'd0, GNT_CPU = 2'd1, GNT_HOST = 2'd2.
- One natural sub-module: arb_wait_counter (saturating counter with clear and force output).
- Muxing and the host read register stay in mem_arbiter.

Test Plan:
- Reset, idle:
  - Stimulus: reset low mid-cycle.
  - Response: host_rvalid = 0, err = 0, mem_rd = mem_wr = 0, no grant.
- Host only:
  - Stimulus: host_req = 1 with writes of 0x11, 0x22, 0x33 to addresses 0, 1, 2, then reads of 0 to 2.
  - Response: mem_wr asserted on 3 consecutive cycles; read data returns 0x11, 0x22, 0x33 with host_rvalid on each following cycle.
- CPU priority:
  - Stimulus: cpu_rd and host_req both asserted in the same cycle, with wait_cnt = 0.
  - Response: mem_adr = cpu_adr, cpu_hold = 0, host_gnt = 0, wait_cnt = 1 after the edge.
- Starvation:
  - Stimulus: CPU requests continuously and host_req = 1 throughout, with MAX_WAIT = 4.
  - Response: host_gnt only on cycle 5; cpu_hold = 1 on that cycle only; pattern repeats every 5 cycles.
- Illegal CPU strobe:
  - Stimulus: cpu_rd = cpu_wr = 1 with no host request.
  - Response: no mem strobe, err = 1 and held until reset.
- Reset mid-read:
  - Stimulus: host read granted, reset asserted before the edge.
  - Response: host_rvalid stays 0; after release a fresh host read completes normally.
